// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } memState_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  // Wide enough for any WAIT_LIMIT in 1..255
  localparam int CNT_W      = 8;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble clears the control bits and holds the data.
module mem_wb_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble,
  input  logic              iRegWrite,
  input  logic              iMemToReg,
  input  logic [DATA_W-1:0] iReadData,
  input  logic [DATA_W-1:0] iAluRes,
  input  logic [REG_W-1:0]  iRegDestMux,
  output logic              oRegWrite,
  output logic              oMemToReg,
  output logic [DATA_W-1:0] oReadData,
  output logic [DATA_W-1:0] oAluRes,
  output logic [REG_W-1:0]  oRegDestMux
);

  always_ff @(posedge clk) begin
    if (rst) begin
      oRegWrite   <= 1'b0;
      oMemToReg   <= 1'b0;
      oReadData   <= '0;
      oAluRes     <= '0;
      oRegDestMux <= '0;
    end else if (bubble) begin
      oRegWrite   <= 1'b0;
      oMemToReg   <= 1'b0;
    end else begin
      oRegWrite   <= iRegWrite;
      oMemToReg   <= iMemToReg;
      oReadData   <= iReadData;
      oAluRes     <= iAluRes;
      oRegDestMux <= iRegDestMux;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: branch resolution, variable-latency data memory access with
// bounded wait and sticky error, and the MEM/WB register.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_W      = DEF_REG_W,
  parameter int WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iRegWrite,
  input  logic              iMemToReg,
  input  logic              iMemWrite,
  input  logic              iMemRead,
  input  logic              iMemBranch,
  input  logic              ijump,
  input  logic [DATA_W-1:0] iAdderSL2Result,
  input  logic              iZFlag,
  input  logic [DATA_W-1:0] iAluRes,
  input  logic [DATA_W-1:0] iData2,
  input  logic [REG_W-1:0]  iRegDestMux,
  output logic              oDmReq,
  output logic              oDmWe,
  output logic [DATA_W-1:0] oDmAddr,
  output logic [DATA_W-1:0] oDmWData,
  input  logic [DATA_W-1:0] iDmRData,
  input  logic              iDmAck,
  output logic              oStall,
  output logic              oPCSrc,
  output logic [DATA_W-1:0] oBranchTarget,
  output logic              oJump,
  output logic              oRegWrite,
  output logic              oMemToReg,
  output logic [DATA_W-1:0] oReadData,
  output logic [DATA_W-1:0] oAluRes,
  output logic [REG_W-1:0]  oRegDestMux,
  output logic              oMemErr
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_LIMIT - 1);

  memState_t         state, stateNxt;
  logic [CNT_W-1:0]  waitCnt;
  logic [DATA_W-1:0] addrLat, wdataLat, rdataLat;
  logic              weLat;
  logic              startAcc, ackTake, timeout, illegalOp;
  logic              memOp, stall;

  assign memOp = iMemRead ^ iMemWrite;

  always_comb begin
    stateNxt  = state;
    stall     = 1'b0;
    startAcc  = 1'b0;
    ackTake   = 1'b0;
    timeout   = 1'b0;
    illegalOp = 1'b0;
    case (state)
      IDLE: begin
        if (memOp) begin
          stall    = 1'b1;
          startAcc = 1'b1;
          stateNxt = WAIT;
        end else if (iMemRead && iMemWrite) begin
          illegalOp = 1'b1;
        end
      end
      WAIT: begin
        stall = 1'b1;
        // An ack in the final wait cycle still beats the timeout
        if (iDmAck) begin
          ackTake  = 1'b1;
          stateNxt = DONE;
        end else if (waitCnt == LAST_CNT) begin
          timeout  = 1'b1;
          stateNxt = DONE;
        end
      end
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // FSM state and access latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      waitCnt  <= '0;
      addrLat  <= '0;
      wdataLat <= '0;
      weLat    <= 1'b0;
      rdataLat <= '0;
      oMemErr  <= 1'b0;
    end else begin
      state <= stateNxt;
      if (startAcc) begin
        addrLat  <= iAluRes;
        wdataLat <= iData2;
        weLat    <= iMemWrite;
        rdataLat <= '0;
        waitCnt  <= '0;
      end else if (state == WAIT) begin
        waitCnt <= waitCnt + CNT_W'(1);
      end
      if (ackTake && !weLat) rdataLat <= iDmRData;
      if (timeout || illegalOp) oMemErr <= 1'b1;
    end
  end

  assign oStall        = stall;
  assign oDmReq        = (state == WAIT);
  assign oDmWe         = (state == WAIT) && weLat;
  assign oDmAddr       = addrLat;
  assign oDmWData      = wdataLat;
  assign oPCSrc        = iMemBranch & iZFlag & ~stall;
  assign oBranchTarget = iAdderSL2Result;
  assign oJump         = ijump & ~stall;

  // MEM/WB boundary
  mem_wb_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) uMemWb (
    .clk         (clk),
    .rst         (rst),
    .bubble      (stall),
    .iRegWrite   (iRegWrite & ~illegalOp),
    .iMemToReg   (iMemToReg),
    .iReadData   ((state == DONE) ? rdataLat : '0),
    .iAluRes     (iAluRes),
    .iRegDestMux (iRegDestMux),
    .oRegWrite   (oRegWrite),
    .oMemToReg   (oMemToReg),
    .oReadData   (oReadData),
    .oAluRes     (oAluRes),
    .oRegDestMux (oRegDestMux)
  );

endmodule
